// File: rtl/router_mesh_gen.sv
// Five-port XY mesh router: per-input FIFOs, round-robin output arbitration, registered outputs.
// Optional saturating discard counter on drop_cnt when ROUTER_DROP_CNT_EN is defined.
module router_mesh_gen #(
  parameter int         DEPTH    = 8,
  parameter int         WIDTH    = 3,
  parameter int         DATASIZE = 40,
  parameter logic [1:0] XPOS     = 2'd0,
  parameter logic [1:0] YPOS     = 2'd0,
  parameter logic [4:0] PORT_EN  = 5'b11111
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [5*DATASIZE-1:0]    data_in,
  input  logic [4:0]               valid_in,
  output logic [4:0]               full_out,
  output logic [5*(WIDTH+1)-1:0]   pressure_out,
  output logic [5*DATASIZE-1:0]    data_out,
  output logic [4:0]               valid_out,
  input  logic [4:0]               full_in
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int         NP      = 5;
  localparam logic [2:0] P_L     = 3'd0;
  localparam logic [2:0] P_E     = 3'd1;
  localparam logic [2:0] P_W     = 3'd2;
  localparam logic [2:0] P_N     = 3'd3;
  localparam logic [2:0] P_S     = 3'd4;
  localparam logic [WIDTH:0]   DEPTH_C = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0]   SKID_C  = (WIDTH+1)'(DEPTH-2);
  localparam logic [WIDTH-1:0] LAST_C  = WIDTH'(DEPTH-1);

  logic [DATASIZE-1:0] r_mem  [NP][DEPTH];
  logic [WIDTH-1:0]    r_wptr [NP];
  logic [WIDTH-1:0]    r_rptr [NP];
  logic [WIDTH:0]      r_cnt  [NP];
  logic [2:0]          r_rr   [NP];
  logic [DATASIZE-1:0] r_dout [NP];
  logic [NP-1:0]       r_vout;

  logic [DATASIZE-1:0] w_head    [NP];
  logic [2:0]          w_route   [NP];
  logic [2:0]          w_gnt_idx [NP];
  logic [NP-1:0]       w_occ;
  logic [NP-1:0]       w_discard;
  logic [NP-1:0]       w_req_ok;
  logic [NP-1:0]       w_wr;
  logic [NP-1:0]       w_pop;
  logic [NP-1:0]       w_gnt_vld;

  function automatic logic [2:0] xy_route(input logic [DATASIZE-1:0] flit);
    logic [1:0] dx;
    logic [1:0] dy;
    dx = flit[DATASIZE-5 -: 2];
    dy = flit[DATASIZE-7 -: 2];
    if (dx > XPOS)      xy_route = P_E;
    else if (dx < XPOS) xy_route = P_W;
    else if (dy > YPOS) xy_route = P_N;
    else if (dy < YPOS) xy_route = P_S;
    else                xy_route = P_L;
  endfunction

  function automatic logic [WIDTH-1:0] ptr_inc(input logic [WIDTH-1:0] ptr);
    ptr_inc = (ptr == LAST_C) ? '0 : ptr + 1'b1;
  endfunction

  // Head decode: route, U-turn / disabled-output discard, write qualification
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_head[p]    = r_mem[p][r_rptr[p]];
      w_route[p]   = xy_route(w_head[p]);
      w_occ[p]     = PORT_EN[p] && (r_cnt[p] != '0);
      w_discard[p] = w_occ[p] && (!PORT_EN[w_route[p]] || (w_route[p] == 3'(p)));
      w_req_ok[p]  = w_occ[p] && !w_discard[p];
      w_wr[p]      = valid_in[p] && PORT_EN[p] && (r_cnt[p] < DEPTH_C);
    end
  end

  // Round-robin per output; scanning offsets high-to-low leaves the nearest requester
  always_comb begin
    logic [3:0] v_sum;
    logic [2:0] v_idx;
    v_sum = '0;
    v_idx = '0;
    for (int o = 0; o < NP; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = '0;
      if (PORT_EN[o] && !full_in[o]) begin
        for (int k = NP-1; k >= 0; k--) begin
          v_sum = {1'b0, r_rr[o]} + 4'(k);
          if (v_sum >= 4'd5) v_sum = v_sum - 4'd5;
          v_idx = v_sum[2:0];
          if (w_req_ok[v_idx] && (w_route[v_idx] == 3'(o))) begin
            w_gnt_vld[o] = 1'b1;
            w_gnt_idx[o] = v_idx;
          end
        end
      end
    end
  end

  always_comb begin
    w_pop = w_discard;
    for (int o = 0; o < NP; o++) begin
      if (w_gnt_vld[o]) w_pop[w_gnt_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (w_wr[p]) r_mem[p][r_wptr[p]] <= data_in[p*DATASIZE +: DATASIZE];
    end
  end

  // FIFO pointers/counts, arbiter pointers, output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        r_wptr[p] <= '0;
        r_rptr[p] <= '0;
        r_cnt[p]  <= '0;
        r_rr[p]   <= '0;
        r_dout[p] <= '0;
      end
      r_vout <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (w_wr[p])  r_wptr[p] <= ptr_inc(r_wptr[p]);
        if (w_pop[p]) r_rptr[p] <= ptr_inc(r_rptr[p]);
        case ({w_wr[p], w_pop[p]})
          2'b10:   r_cnt[p] <= r_cnt[p] + 1'b1;
          2'b01:   r_cnt[p] <= r_cnt[p] - 1'b1;
          default: r_cnt[p] <= r_cnt[p];
        endcase
      end
      for (int o = 0; o < NP; o++) begin
        if (w_gnt_vld[o]) begin
          r_dout[o] <= w_head[w_gnt_idx[o]];
          r_rr[o]   <= (w_gnt_idx[o] == 3'd4) ? 3'd0 : w_gnt_idx[o] + 3'd1;
        end
      end
      r_vout <= w_gnt_vld;
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      full_out[p] = PORT_EN[p] ? (r_cnt[p] >= SKID_C) : 1'b1;
      pressure_out[p*(WIDTH+1) +: (WIDTH+1)] = PORT_EN[p] ? r_cnt[p] : '0;
      data_out[p*DATASIZE +: DATASIZE] = r_dout[p];
    end
  end

  assign valid_out = r_vout;

`ifdef ROUTER_DROP_CNT_EN
  logic [3:0] w_drop_n;
  logic [8:0] w_drop_sum;
  logic [7:0] r_drop;

  // Discards per cycle: overflow writes plus unroutable head pops
  always_comb begin
    w_drop_n = '0;
    for (int p = 0; p < NP; p++) begin
      w_drop_n = w_drop_n + 4'(w_discard[p])
               + 4'(valid_in[p] && PORT_EN[p] && (r_cnt[p] == DEPTH_C));
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + 9'(w_drop_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop <= '0;
    else        r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  assign drop_cnt = r_drop;
`endif

endmodule

// File: tb/tb_router_mesh_gen.sv
// Bench for router_mesh_gen: a full-mask node and an edge node (PORT_EN=10101) at (1,1),
// both checked every cycle against a queue-based reference model.
module tb_router_mesh_gen;

  localparam int         DS    = 40;
  localparam int         DEPTH = 8;
  localparam logic [4:0] EN0   = 5'b11111;
  localparam logic [4:0] EN1   = 5'b10101;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [199:0] din;
  logic [4:0]   vin, fin;
  logic [4:0]   fo0, fo1, vo0, vo1;
  logic [19:0]  pr0, pr1;
  logic [199:0] do0, do1;
`ifdef ROUTER_DROP_CNT_EN
  logic [7:0]   dc0, dc1;
`endif

  always #5 clk = ~clk;

  router_mesh_gen #(.DEPTH(8), .WIDTH(3), .DATASIZE(DS), .XPOS(2'd1), .YPOS(2'd1), .PORT_EN(EN0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin), .full_out(fo0),
    .pressure_out(pr0), .data_out(do0), .valid_out(vo0), .full_in(fin)
`ifdef ROUTER_DROP_CNT_EN
    , .drop_cnt(dc0)
`endif
  );

  router_mesh_gen #(.DEPTH(8), .WIDTH(3), .DATASIZE(DS), .XPOS(2'd1), .YPOS(2'd1), .PORT_EN(EN1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin), .full_out(fo1),
    .pressure_out(pr1), .data_out(do1), .valid_out(vo1), .full_in(fin)
`ifdef ROUTER_DROP_CNT_EN
    , .drop_cnt(dc1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one queue per (dut, input); index d*5+p
  logic [DS-1:0] mq [10][$];
  int            m_rr   [2][5];
  logic [DS-1:0] e_dout [2][5];
  logic [4:0]    e_vout [2];
  int            m_drop [2];

  function automatic int route_of(input logic [DS-1:0] f);
    int dx, dy;
    dx = int'(f[DS-5 -: 2]);
    dy = int'(f[DS-7 -: 2]);
    if (dx > 1) return 1;
    if (dx < 1) return 2;
    if (dy > 1) return 3;
    if (dy < 1) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 5; p++) begin
        mq[d*5+p].delete();
        m_rr[d][p]   = 0;
        e_dout[d][p] = '0;
      end
      e_vout[d] = '0;
      m_drop[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [4:0] en);
    int r [5];
    int sz [5];
    bit pop [5];
    int drops, p;
    bit done;
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      sz[i]  = mq[d*5+i].size();
      pop[i] = 1'b0;
      r[i]   = -1;
      if (en[i] && sz[i] > 0) begin
        r[i] = route_of(mq[d*5+i][0]);
        if (!en[r[i]] || r[i] == i) begin
          pop[i] = 1'b1;
          drops++;
          r[i] = -1;
        end
      end
    end
    e_vout[d] = '0;
    for (int o = 0; o < 5; o++) begin
      done = 1'b0;
      if (en[o] && !fin[o]) begin
        for (int k = 0; k < 5; k++) begin
          p = (m_rr[d][o] + k) % 5;
          if (!done && r[p] == o) begin
            e_dout[d][o] = mq[d*5+p][0];
            e_vout[d][o] = 1'b1;
            m_rr[d][o]   = (p + 1) % 5;
            pop[p]       = 1'b1;
            done         = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (pop[i]) void'(mq[d*5+i].pop_front());
      if (vin[i] && en[i]) begin
        if (sz[i] < DEPTH) mq[d*5+i].push_back(din[i*DS +: DS]);
        else drops++;
      end
    end
    m_drop[d] = (m_drop[d] + drops > 255) ? 255 : m_drop[d] + drops;
  endtask

  task automatic compare(input int d);
    logic [4:0]   en, vo, fo, ef;
    logic [19:0]  pr, ep;
    logic [199:0] dq, ed;
    en = d ? EN1 : EN0;
    vo = d ? vo1 : vo0;
    fo = d ? fo1 : fo0;
    pr = d ? pr1 : pr0;
    dq = d ? do1 : do0;
    for (int p = 0; p < 5; p++) begin
      ed[p*DS +: DS] = e_dout[d][p];
      ep[p*4 +: 4]   = en[p] ? 4'(mq[d*5+p].size()) : 4'd0;
      ef[p]          = en[p] ? (mq[d*5+p].size() >= DEPTH-2) : 1'b1;
    end
    check($sformatf("d%0d_valid_out", d), 200'(vo), 200'(e_vout[d]));
    check($sformatf("d%0d_data_out", d), dq, ed);
    check($sformatf("d%0d_full_out", d), 200'(fo), 200'(ef));
    check($sformatf("d%0d_pressure", d), 200'(pr), 200'(ep));
`ifdef ROUTER_DROP_CNT_EN
    check($sformatf("d%0d_drop_cnt", d), 200'(d ? dc1 : dc0), 200'(m_drop[d]));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_step(0, EN0);
      model_step(1, EN1);
    end
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vin   = '0;
    fin   = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic xy_route_test(input string tag, input logic [31:0] pay);
    logic [DS-1:0] f;
    f = {4'h0, 4'b1101, pay};
    din = '0;
    din[0 +: DS] = f;
    vin = 5'b00001;
    step();
    vin = '0;
    check({tag, "_c1_valid"}, 200'(vo0), 200'(5'b0));
    step();
    check({tag, "_c2_valid"}, 200'(vo0), 200'(5'b00010));
    check({tag, "_c2_data"}, 200'(do0[DS +: DS]), 200'(f));
    step();
    check({tag, "_c3_valid"}, 200'(vo0), 200'(5'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ord [4];
    int cnt;
    logic [7:0] seq;
    int dbefore;
    int pv, pf;
    ord = '{0, 2, 3, 4};
    rst_n = 1'b0;
    vin = '0;
    fin = '0;
    din = '0;
    dbefore = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare(0);
    compare(1);
    check("rst_full0", 200'(fo0), 200'(5'b00000));
    check("rst_full1", 200'(fo1), 200'(5'b01010));
    check("rst_valid", 200'(vo0), 200'(5'b0));
    rst_n = 1'b1;

    xy_route_test("xy", 32'hCAFE_0001);

    // Back-pressure: 6 flits on W towards blocked E
    fin = 5'b00010;
    for (int i = 0; i < 6; i++) begin
      din = '0;
      din[2*DS +: DS] = {4'h2, 4'b1100, 32'(i + 100)};
      vin = 5'b00100;
      step();
    end
    vin = '0;
    check("bp_pressure_w", 200'(pr0[8 +: 4]), 200'(4'd6));
    check("bp_full_w", 200'(fo0[2]), 200'(1'b1));
    fin = '0;
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      seq[i] = vo0[1];
    end
    check("bp_pulses", 200'(seq), 200'(8'b0011_1111));
    check("bp_full_w_after", 200'(fo0[2]), 200'(1'b0));

    // Overflow: 9 writes on L with E blocked
`ifdef ROUTER_DROP_CNT_EN
    dbefore = int'(dc0);
`endif
    fin = 5'b00010;
    for (int i = 0; i < 9; i++) begin
      din = '0;
      din[0 +: DS] = {4'h0, 4'b1100, 32'(i + 200)};
      vin = 5'b00001;
      step();
    end
    vin = '0;
    check("ov_pressure_l", 200'(pr0[3:0]), 200'(4'd8));
    check("ov_full_l", 200'(fo0[0]), 200'(1'b1));
`ifdef ROUTER_DROP_CNT_EN
    check("ov_drop_delta", 200'(int'(dc0) - dbefore), 200'(1));
`endif
    fin = '0;
    repeat (10) step();

    // Disabled port on the edge node
    do_reset();
    din = '0;
    din[0 +: DS]  = {4'h0, 4'b1101, 32'h0000_D15A};
    din[DS +: DS] = {4'h1, 4'b0101, 32'h0000_E0E0};
    vin = 5'b00011;
    step();
    vin = '0;
    check("dis_pressure_e", 200'(pr1[4 +: 4]), 200'(4'd0));
    check("dis_full_e", 200'(fo1[1]), 200'(1'b1));
    step();
    check("dis_valid_c2", 200'(vo1), 200'(5'b0));
    step();
    check("dis_valid_c3", 200'(vo1), 200'(5'b0));
`ifdef ROUTER_DROP_CNT_EN
    check("dis_drop", 200'(dc1), 200'(8'd1));
`endif

    // Round-robin: L, W, N, S each hold 3 flits for E
    do_reset();
    fin = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      din = '0;
      for (int p = 0; p < 5; p++) din[p*DS +: DS] = {4'(p), 4'b1100, 28'(i), 4'(p)};
      vin = 5'b11101;
      step();
    end
    vin = '0;
    fin = '0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (vo0[1]) begin
        check($sformatf("rr_grant%0d", cnt), 200'(do0[DS +: 4]), 200'(ord[cnt % 4]));
        cnt++;
      end
    end
    check("rr_total", 200'(cnt), 200'(12));

    // Randomised traffic in three load regimes
    for (int seg = 0; seg < 3; seg++) begin
      pv = (seg == 0) ? 30 : (seg == 1) ? 80 : 95;
      pf = (seg == 0) ? 10 : (seg == 1) ? 50 : 5;
      for (int c = 0; c < 400; c++) begin
        for (int p = 0; p < 5; p++) begin
          din[p*DS +: DS] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'($urandom)};
          vin[p] = ($urandom_range(0, 99) < pv);
          fin[p] = ($urandom_range(0, 99) < pf);
        end
        step();
      end
    end

    // Reset while queues are loaded
    rst_n = 1'b0;
    vin = '0;
    fin = '0;
    #1;
    check("mid_rst_valid", 200'(vo0), 200'(5'b0));
    check("mid_rst_data", do0, 200'(0));
    check("mid_rst_pressure", 200'(pr0), 200'(0));
    check("mid_rst_full0", 200'(fo0), 200'(5'b00000));
    check("mid_rst_full1", 200'(fo1), 200'(5'b01010));
`ifdef ROUTER_DROP_CNT_EN
    check("mid_rst_drop", 200'(dc1), 200'(0));
`endif
    model_reset();
    compare(0);
    compare(1);
    @(negedge clk);
    rst_n = 1'b1;
    xy_route_test("post_rst", 32'hBEEF_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_mesh_gen.md
# router_mesh_gen

Parametrised five-port mesh router, the successor to the three-port router generation. It buffers each input port in its own FIFO and routes head flits by dimension-ordered XY routing on the 4-bit destination field. It grants each output by round-robin and drives registered output ports under full/pressure flow control. One instance sits at every mesh node; edge and corner nodes disable unused ports through a mask parameter instead of using hand-edited variants.

## Interface
- DEPTH, 8, per-input FIFO depth in flits; must be ≥ 4.
- WIDTH, 3, log2(DEPTH); occupancy counters are WIDTH+1 bits.
- DATASIZE, 40, flit width; src is [DATASIZE-1:DATASIZE-4], dst is [DATASIZE-5:DATASIZE-8] ({x[1:0], y[1:0]}).
- XPOS, 0, this node's x coordinate (2 bits).
- YPOS, 0, this node's y coordinate (2 bits).
- PORT_EN, 5'b11111, port enable mask; index 0 = L, 1 = E (x+1), 2 = W (x-1), 3 = N (y+1), 4 = S (y-1).

Ports:
- clk  in  1  single clock; every register is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- data_in  in  5*DATASIZE  input flits; port p occupies slice [p*DATASIZE +: DATASIZE].
- valid_in  in  5  per-input write strobe.
- full_out  out  5  per-input back-pressure to the upstream node.
- pressure_out  out  5*(WIDTH+1)  per-input FIFO occupancy.
- data_out  out  5*DATASIZE  registered output flits.
- valid_out  out  5  registered per-output valid; one-cycle pulse per flit.
- full_in  in  5  per-output downstream back-pressure.
- drop_cnt  out  8  saturating count of discarded flits; present only with ROUTER_DROP_CNT_EN.

## Operation
- **Reset values.** All FIFOs empty. full_out = ~PORT_EN. pressure_out, valid_out, data_out and drop_cnt are 0. All round-robin pointers are 0.
- **FIFO write.** Input p writes when valid_in[p] is high, PORT_EN[p] is set and count < DEPTH.
  - valid_in while count == DEPTH is a protocol violation; the flit is dropped.
  - valid_in on a disabled port is ignored.
- **Back-pressure.** full_out[p] = (count_p ≥ DEPTH-2); this gives a two-slot skid reserve for the round trip. Disabled ports hold full_out at 1 and pressure_out at 0.
- **Route computation.** Combinational on each non-empty FIFO head, with dx = dst[3:2] and dy = dst[1:0]:
  - dx > XPOS → E; dx < XPOS → W.
  - Otherwise dy > YPOS → N; dy < YPOS → S.
  - Otherwise → L.
- **Unroutable head.** A head whose route is a disabled output, or whose route equals its own input port (U-turn), is popped and discarded with no output.
- **Switch allocation.** For each enabled output o, the requesters are inputs whose routable head targets o.
  - o is eligible when full_in[o] is low.
  - A round-robin arbiter grants one requester and pops its FIFO.
  - The pointer moves to (granted index + 1) mod 5. With no grant, the pointer holds.
  - Each head targets exactly one output, so one input is never granted twice.
- **Output register.** On a grant, data_out[o] takes the flit and valid_out[o] = 1 for that cycle. With no grant, valid_out[o] = 0 and data_out[o] holds its last value.
- **Simultaneous write and pop.** Both take effect in the same cycle and the count is unchanged.

## Timing
- Minimum latency is 2 cycles: valid_in sampled in cycle c → head visible and granted in cycle c+1 → valid_out high in cycle c+2.
- Throughput is one flit per output per cycle and one pop per input per cycle.
- full_in is sampled combinationally in the grant cycle. A flit already registered on data_out is not recalled.
- full_out and pressure_out reflect the count after the previous edge; there is no extra register stage.
- Reset asserted mid-operation immediately empties all FIFOs and clears every output; in-flight flits are lost.

## Configuration
- ROUTER_DROP_CNT_EN defined:
  - The drop_cnt port exists.
  - It increments by the number of flits discarded in the cycle (overflow writes plus unroutable pops), saturating at 255.
  - Reset clears it to 0.
- ROUTER_DROP_CNT_EN undefined: no drop_cnt port and no counter logic. Drop behaviour is otherwise identical.

## Test plan
- **Basic XY route.** XPOS=1, YPOS=1; flit dst=4'b1101 written on L in cycle 0 → valid_out[E] high in cycle 2 with identical data; all other valid_out stay 0.
- **Round-robin fairness.** L, W, N and S heads all target E with full_in = 0, and each FIFO holds 3 flits → E grants rotate L, W, N, S, L, …; no input is granted twice before every other requester has been served.
- **Back-pressure.** DEPTH=8; write 6 flits to W while full_in[E] = 1 → pressure_out[W] = 6 and full_out[W] = 1. Release full_in → 6 valid_out[E] pulses on consecutive cycles, then full_out[W] = 0.
- **Disabled port.** PORT_EN = 5'b10101; flit routed to E → discarded, and drop_cnt = 1 (macro on). valid_in[E] is ignored and full_out[E] = 1.
- **Overflow.** Force 9 writes to L with no grant possible → pressure_out[L] = 8, and drop_cnt increments by 1.
- **Reset during traffic.** Assert rst_n low while flits are queued → all outputs 0 immediately. After release, a new flit routes with 2-cycle latency.
